mtc_ppa_sched: RTL
==================

# mtc_ppa_sched

Multi-grant round-robin scheduler for the mTC-PPA arbiter: accepts a request vector, grants up to AMOUNT_M requesters at once in circular priority order, and tracks granted requesters until each releases. It sits in front of the grant-conversion stage and owns the priority pointer, outstanding-grant bookkeeping and valid/ready sequencing for the grant path.

## Interface
- WIDTH_N, 4: number of requesters; ≥2.
- AMOUNT_M, 2: maximum simultaneously outstanding grants; 1 ≤ AMOUNT_M ≤ WIDTH_N.
- PTR_W, $clog2(WIDTH_N): derived pointer width; do not override.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_i  in  WIDTH_N  request vector, bit i = requester i.
- req_vld_i  in  1  request vector valid.
- req_rdy_o  out  1  scheduler can accept a request vector.
- gnt_o  out  WIDTH_N  granted requesters; popcount ≤ AMOUNT_M.
- gnt_vld_o  out  1  gnt_o valid.
- gnt_rdy_i  in  1  downstream accepts gnt_o.
- rel_i  in  WIDTH_N  release strobes; bit i frees requester i.
- busy_o  out  WIDTH_N  requesters currently holding a grant.
- ptr_o  out  PTR_W  current highest-priority index.

## Operation
- State: req_q, gnt_q, busy_q (WIDTH_N each), ptr_q (PTR_W), FSM IDLE/ARB/OFFER.
- free = AMOUNT_M − popcount(busy_q), width $clog2(AMOUNT_M+1).
- IDLE: req_rdy_o = (free ≠ 0). On req_vld_i && req_rdy_o: req_q ← req_i & ~busy_q & ~rel_i... no: req_q ← req_i & ~busy_q; go ARB.
- ARB (one cycle): scan indices ptr_q, ptr_q+1, … mod WIDTH_N; set gnt_q bit for the first min(free, popcount(req_q & ~busy_q)) requesting bits. If none, gnt_q ← 0 and go IDLE (no output). Else go OFFER.
- OFFER: gnt_vld_o = 1, gnt_o = gnt_q held stable until gnt_rdy_i. On handshake: busy_q |= gnt_q; ptr_q ← (index of last bit granted in scan order + 1) mod WIDTH_N; go IDLE.
- Release: every cycle busy_q &= ~rel_i. Release of a non-busy bit is ignored.
- Same-cycle release and grant handshake on the same bit: grant wins (bit ends busy).
- Releases during ARB/OFFER do not alter gnt_q; new capacity is seen at next IDLE.
- req_rdy_o = 0 in ARB and OFFER; gnt_vld_o = 0 in IDLE and ARB.

## Timing
- Reset values: req_rdy_o 1 (free = AMOUNT_M), gnt_o 0, gnt_vld_o 0, busy_o 0, ptr_o 0; FSM IDLE.
- Reset is asynchronous: asserted mid-OFFER, gnt_vld_o drops without waiting for an edge; all grants and busy bits are discarded.
- Latency: request handshake in cycle T → gnt_vld_o high in T+2 (IDLE→ARB→OFFER).
- busy_o updates the cycle after the grant handshake or the release strobe.
- Back-to-back: after an OFFER handshake in T, req_rdy_o may be high in T+1. Minimum 3 cycles per request.
- All outputs are registered or decoded from FSM state; no combinational path from req_i/rel_i to outputs.

## Configuration
- MTC_PPA_SCHED_RR_EN defined: round-robin, ptr_q updated on each grant handshake as above.
- Not defined: fixed priority; ptr_q held at 0 (index 0 highest), ptr_o tied to 0, pointer update logic removed.

## Test plan
- After reset, N=4, M=2: req_i 4'b1111 → gnt_o 4'b0011 at T+2; after handshake busy_o 4'b0011, ptr_o 2, req_rdy_o 0.
- From busy 4'b0011, ptr 2: rel_i 4'b0001 → req_rdy_o 1 next cycle; req_i 4'b1111 → gnt_o 4'b0100, ptr_o 3, busy_o 4'b0110.
- Wrap-around: busy 0, ptr 3, req_i 4'b1001 → gnt_o 4'b1001, ptr_o 1 after handshake.
- Backpressure: gnt_rdy_i low 5 cycles in OFFER → gnt_o/gnt_vld_o stable, req_rdy_o 0, busy_o unchanged; rel_i 4'b0001 in that window clears busy bit 0 only.
- Masked-empty: busy 4'b0001, req_i 4'b0001 → ARB finds none, gnt_vld_o never rises, FSM back to IDLE at T+2.
- Reset asserted mid-OFFER → gnt_vld_o 0 same cycle, busy_o 0, ptr_o 0; without MTC_PPA_SCHED_RR_EN, repeated req_i 4'b1111 always grants 4'b0011.

Source files
------------

// File: rtl/mtc_ppa_sched_if.sv
// Grant-path handshake bundle for mtc_ppa_sched: request, grant, release and status.
// master = requester/downstream side, slave = scheduler.
interface mtc_ppa_sched_if #(
    parameter int WIDTH_N = 4,
    parameter int PTR_W   = $clog2(WIDTH_N)
);
    logic [WIDTH_N-1:0] req_i;
    logic               req_vld_i;
    logic               req_rdy_o;
    logic [WIDTH_N-1:0] gnt_o;
    logic               gnt_vld_o;
    logic               gnt_rdy_i;
    logic [WIDTH_N-1:0] rel_i;
    logic [WIDTH_N-1:0] busy_o;
    logic [PTR_W-1:0]   ptr_o;

    modport master (
        output req_i, req_vld_i, gnt_rdy_i, rel_i,
        input  req_rdy_o, gnt_o, gnt_vld_o, busy_o, ptr_o
    );

    modport slave (
        input  req_i, req_vld_i, gnt_rdy_i, rel_i,
        output req_rdy_o, gnt_o, gnt_vld_o, busy_o, ptr_o
    );
endinterface

// File: rtl/mtc_ppa_sched.sv
// Multi-grant scheduler: grants up to AMOUNT_M requesters per round and tracks them until release.
// MTC_PPA_SCHED_RR_EN selects rotating priority; undefined gives fixed priority with index 0 highest.
module mtc_ppa_sched #(
    parameter int WIDTH_N  = 4,
    parameter int AMOUNT_M = 2,
    parameter int PTR_W    = $clog2(WIDTH_N)
) (
    input  logic           clk,
    input  logic           reset,
    mtc_ppa_sched_if.slave bus
);
    localparam int FREE_W = $clog2(AMOUNT_M + 1);
    localparam int CNT_W  = $clog2(WIDTH_N + 1);

    typedef enum logic [1:0] {IDLE, ARB, OFFER} state_t;

    state_t             state_q, state_nxt;
    logic [WIDTH_N-1:0] req_q;
    logic [WIDTH_N-1:0] gnt_q;
    logic [WIDTH_N-1:0] gnt_nxt;
    logic [WIDTH_N-1:0] busy_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   idx;
    logic [FREE_W-1:0]  free;
    logic [FREE_W-1:0]  free_q;
    logic [FREE_W-1:0]  cnt;
    logic [CNT_W-1:0]   busy_cnt;
    logic               req_hs;
    logic               gnt_hs;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= WIDTH_N) sum = sum - WIDTH_N;
        return PTR_W'(sum);
    endfunction

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < WIDTH_N; i++) busy_cnt = busy_cnt + CNT_W'(busy_q[i]);
    end

    assign free   = FREE_W'(AMOUNT_M) - FREE_W'(busy_cnt);
    assign req_hs = (state_q == IDLE) && bus.req_vld_i && (free != '0);
    assign gnt_hs = (state_q == OFFER) && bus.gnt_rdy_i;

`ifdef MTC_PPA_SCHED_RR_EN
    logic [PTR_W-1:0] last_idx;
    logic [PTR_W-1:0] ptr_nxt_q;

    // Pointer advance is computed during ARB but only committed on the grant handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            ptr_nxt_q <= '0;
        end else begin
            if (state_q == ARB) ptr_nxt_q <= wrap_idx(last_idx, 1);
            if (gnt_hs)         ptr_q     <= ptr_nxt_q;
        end
    end
`else
    assign ptr_q = '0;
`endif

    // Circular scan from the pointer; capacity is the snapshot taken at request acceptance.
    always_comb begin
        gnt_nxt = '0;
        cnt     = '0;
        idx     = '0;
`ifdef MTC_PPA_SCHED_RR_EN
        last_idx = ptr_q;
`endif
        for (int k = 0; k < WIDTH_N; k++) begin
            idx = wrap_idx(ptr_q, k);
            if (req_q[idx] && (cnt < free_q)) begin
                gnt_nxt[idx] = 1'b1;
                cnt          = cnt + FREE_W'(1);
`ifdef MTC_PPA_SCHED_RR_EN
                last_idx     = idx;
`endif
            end
        end
    end

    always_comb begin
        state_nxt     = state_q;
        bus.req_rdy_o = 1'b0;
        bus.gnt_vld_o = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_rdy_o = (free != '0);
                if (req_hs) state_nxt = ARB;
            end
            ARB:     state_nxt = (gnt_nxt != '0) ? OFFER : IDLE;
            OFFER: begin
                bus.gnt_vld_o = 1'b1;
                if (bus.gnt_rdy_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant handshake ORs in after the release mask, so a coincident release loses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_nxt;
            busy_q  <= (busy_q & ~bus.rel_i) | (gnt_hs ? gnt_q : '0);
            if (state_q == ARB) gnt_q <= gnt_nxt;
            else if (gnt_hs)    gnt_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (req_hs) begin
            req_q  <= bus.req_i & ~busy_q;
            free_q <= free;
        end
    end

    assign bus.gnt_o  = gnt_q;
    assign bus.busy_o = busy_q;
    assign bus.ptr_o  = ptr_q;
endmodule
